// File: rtl/ttl_163_chain_seq_if.sv
// rtl/ttl_163_chain_seq_if.sv - control/status bus between the sequencer and a 74163 counter chain
interface ttl_163_chain_seq_if #(
  parameter int WIDTH = 8
);
  logic             Clear_bar;
  logic             Load_bar;
  logic             ENT;
  logic             ENP;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q_in;
  logic             RCO_in;

  // Sequencer side: drives the chain controls, observes Q and RCO
  modport master (
    output Clear_bar, Load_bar, ENT, ENP, D,
    input  Q_in, RCO_in
  );

  // Counter chain side
  modport slave (
    input  Clear_bar, Load_bar, ENT, ENP, D,
    output Q_in, RCO_in
  );
endinterface

// File: rtl/ttl_163_chain_seq.sv
// rtl/ttl_163_chain_seq.sv - start/stop/pause sequencer for a 74163 chain; optional SEQ163_RCO_CHECK_EN
module ttl_163_chain_seq #(
  parameter int WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset_bar,
  input  logic                   Cen,
  input  logic                   Start,
  input  logic                   Stop,
  input  logic                   Pause,
  input  logic                   Mode,
  input  logic [WIDTH-1:0]       Load_val,
  input  logic [WIDTH-1:0]       Term_val,
  ttl_163_chain_seq_if.master    ch,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Wrap,
  output logic                   Err
);

  typedef enum logic [2:0] {S_CLR, S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic             last_cen;
  logic             tick;
  logic             clear_q, clear_n;
  logic             load_q, load_n;
  logic             ent_q, ent_n;
  logic             enp_q, enp_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic             done_q, done_n;
  logic             wpend_q, wpend_n;
  logic             wrap_q;
  logic [WIDTH-1:0] pred;
  logic             term_hit;

  assign tick = Cen & ~last_cen;

  // Cen edge detector runs every Clk; starts high so a Cen already high is not a tick
  always_ff @(posedge Clk or negedge Reset_bar) begin
    if (!Reset_bar) last_cen <= 1'b1;
    else            last_cen <= Cen;
  end

  // State and control registers advance only on a tick
  always_ff @(posedge Clk or negedge Reset_bar) begin
    if (!Reset_bar) begin
      state   <= S_CLR;
      clear_q <= 1'b0;
      load_q  <= 1'b1;
      ent_q   <= 1'b0;
      enp_q   <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
      wpend_q <= 1'b0;
    end else if (tick) begin
      state   <= state_n;
      clear_q <= clear_n;
      load_q  <= load_n;
      ent_q   <= ent_n;
      enp_q   <= enp_n;
      d_q     <= d_n;
      done_q  <= done_n;
      wpend_q <= wpend_n;
    end
  end

  // Wrap is a one-Clk pulse on the tick where the chain applies a reload
  always_ff @(posedge Clk or negedge Reset_bar) begin
    if (!Reset_bar) wrap_q <= 1'b0;
    else            wrap_q <= tick & wpend_q;
  end

  // Next state and next controls; pred is what the chain will hold after this tick
  always_comb begin
    pred     = !load_q ? d_q : ((ent_q & enp_q) ? ch.Q_in + ONE : ch.Q_in);
    term_hit = (pred == Term_val);
    state_n  = state;
    clear_n  = 1'b1;
    load_n   = 1'b1;
    ent_n    = ent_q;
    enp_n    = enp_q;
    d_n      = d_q;
    done_n   = done_q;
    wpend_n  = 1'b0;
    if (Stop) begin
      state_n = S_CLR;
      clear_n = 1'b0;
      ent_n   = 1'b0;
      enp_n   = 1'b0;
      done_n  = 1'b0;
    end else begin
      case (state)
        S_CLR: begin
          state_n = S_IDLE;
          ent_n   = 1'b0;
          enp_n   = 1'b0;
        end
        S_IDLE, S_DONE: begin
          ent_n = 1'b0;
          enp_n = 1'b0;
          if (Start) begin
            state_n = S_LOAD;
            load_n  = 1'b0;
            d_n     = Load_val;
            done_n  = 1'b0;
          end
        end
        S_LOAD, S_RUN: begin
          if (term_hit) begin
            if (!Mode) begin
              state_n = S_RUN;
              load_n  = 1'b0;
              d_n     = Load_val;
              ent_n   = 1'b1;
              enp_n   = 1'b1;
              wpend_n = 1'b1;
            end else begin
              state_n = S_DONE;
              ent_n   = 1'b0;
              enp_n   = 1'b0;
              done_n  = 1'b1;
            end
          end else if (state == S_RUN && Pause) begin
            state_n = S_PAUSE;
            ent_n   = 1'b1;
            enp_n   = 1'b0;
          end else begin
            state_n = S_RUN;
            ent_n   = 1'b1;
            enp_n   = 1'b1;
          end
        end
        S_PAUSE: begin
          ent_n = 1'b1;
          enp_n = 1'b0;
          if (!Pause) begin
            state_n = S_RUN;
            enp_n   = 1'b1;
          end
        end
        default: begin
          state_n = S_CLR;
          clear_n = 1'b0;
          ent_n   = 1'b0;
          enp_n   = 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ163_RCO_CHECK_EN
  logic err_q;

  // Sticky flag when the chain's RCO disagrees with ENT & all-ones Q
  always_ff @(posedge Clk or negedge Reset_bar) begin
    if (!Reset_bar)                                 err_q <= 1'b0;
    else if (tick && Stop)                          err_q <= 1'b0;
    else if (tick && (ch.RCO_in != (ent_q & (&ch.Q_in)))) err_q <= 1'b1;
  end

  assign Err = err_q;
`else
  logic unused_rco;
  assign unused_rco = ch.RCO_in;
  assign Err        = 1'b0;
`endif

  assign ch.Clear_bar = clear_q;
  assign ch.Load_bar  = load_q;
  assign ch.ENT       = ent_q;
  assign ch.ENP       = enp_q;
  assign ch.D         = d_q;
  assign Busy         = (state == S_LOAD) || (state == S_RUN) || (state == S_PAUSE);
  assign Done         = done_q;
  assign Wrap         = wrap_q;

endmodule

// File: tb/tb_ttl_163_chain_seq.sv
// tb/tb_ttl_163_chain_seq.sv - directed bench driving a behavioural 74163 chain from the sequencer
module tb_ttl_163_chain_seq;
  localparam int W = 8;
`ifdef SEQ163_RCO_CHECK_EN
  localparam int RCO_CHK = 1;
`else
  localparam int RCO_CHK = 0;
`endif

  logic         Clk = 1'b0;
  logic         Reset_bar, Cen, Start, Stop, Pause, Mode;
  logic [W-1:0] Load_val, Term_val;
  logic         Busy, Done, Wrap, Err;
  int           n_chk = 0;
  int           n_fail = 0;

  logic [W-1:0] q = 8'hA5;
  logic         tb_last = 1'b1;
  logic         rco_kill = 1'b0;

  always #5 Clk = ~Clk;

  ttl_163_chain_seq_if #(.WIDTH(W)) ch ();

  ttl_163_chain_seq #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset_bar(Reset_bar),
    .Cen      (Cen),
    .Start    (Start),
    .Stop     (Stop),
    .Pause    (Pause),
    .Mode     (Mode),
    .Load_val (Load_val),
    .Term_val (Term_val),
    .ch       (ch),
    .Busy     (Busy),
    .Done     (Done),
    .Wrap     (Wrap),
    .Err      (Err)
  );

  // Behavioural 74163 chain: synchronous clear > load > count, on the same Cen edge
  always @(posedge Clk) begin
    if (Cen && !tb_last) begin
      if (!ch.Clear_bar)          q <= '0;
      else if (!ch.Load_bar)      q <= ch.D;
      else if (ch.ENT && ch.ENP)  q <= q + 8'd1;
    end
    tb_last <= Cen;
  end

  assign ch.Q_in   = q;
  assign ch.RCO_in = rco_kill ? 1'b0 : (ch.ENT & (&q));

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    Cen = 1'b1;
    @(negedge Clk);
    Cen = 1'b0;
  endtask

  task automatic tick_hold(input int n);
    @(negedge Clk);
    Cen = 1'b1;
    repeat (n) @(negedge Clk);
    Cen = 1'b0;
  endtask

  task automatic tq(input string tag, input int exp_q, input int exp_w);
    tick();
    check({tag, "_q"}, q, exp_q);
    check({tag, "_wrap"}, Wrap, exp_w);
  endtask

  initial begin
    Reset_bar = 1'b0; Cen = 1'b0; Start = 1'b0; Stop = 1'b0; Pause = 1'b0; Mode = 1'b0;
    Load_val = 8'h05; Term_val = 8'h08;
    repeat (3) @(negedge Clk);
    check("rst_clear", ch.Clear_bar, 0);
    check("rst_load", ch.Load_bar, 1);
    check("rst_ent", ch.ENT, 0);
    check("rst_enp", ch.ENP, 0);
    check("rst_d", ch.D, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_wrap", Wrap, 0);
    check("rst_err", Err, 0);
    Reset_bar = 1'b1;
    repeat (4) @(negedge Clk);
    check("no_cen_clear", ch.Clear_bar, 0);
    tick();
    check("clr_clear", ch.Clear_bar, 1);
    check("clr_q", q, 8'h00);
    check("idle_busy", Busy, 0);

    // Free-run 05..08
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_load", ch.Load_bar, 0);
    check("start_d", ch.D, 8'h05);
    check("start_busy", Busy, 1);
    check("start_q", q, 8'h00);
    tq("fr0", 8'h05, 0);
    tick_hold(5);
    check("cen_high_q", q, 8'h06);
    tq("fr2", 8'h07, 0);
    tq("fr3", 8'h08, 0);
    tq("fr4", 8'h05, 1);
    Start = 1'b1;
    tq("busy_start", 8'h06, 0);
    Start = 1'b0;
    tq("fr6", 8'h07, 0);
    tq("fr7", 8'h08, 0);
    tq("fr8", 8'h05, 1);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check("stop_clear", ch.Clear_bar, 0);
    check("stop_busy", Busy, 0);
    tick();
    check("stop_q", q, 8'h00);
    check("stop_clear_rel", ch.Clear_bar, 1);

    // One-shot, restart, pause
    Mode = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tq("os0", 8'h05, 0);
    tq("os1", 8'h06, 0);
    tq("os2", 8'h07, 0);
    tq("os3", 8'h08, 0);
    check("os_done", Done, 1);
    check("os_busy", Busy, 0);
    tq("os_hold", 8'h08, 0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("re_done", Done, 0);
    check("re_busy", Busy, 1);
    tq("re0", 8'h05, 0);
    Pause = 1'b1;
    tq("pz0", 8'h06, 0);
    tq("pz1", 8'h06, 0);
    tq("pz2", 8'h06, 0);
    Pause = 1'b0;
    tq("pz3", 8'h06, 0);
    tq("pz_res", 8'h07, 0);
    tq("pz_end", 8'h08, 0);
    check("pz_done", Done, 1);

    // Load_val == Term_val: reload every tick
    Mode = 1'b0; Load_val = 8'h0F; Term_val = 8'h0F;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tq("eq0", 8'h0F, 0);
    tq("eq1", 8'h0F, 1);
    tq("eq2", 8'h0F, 1);
    tq("eq3", 8'h0F, 1);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check("eq_stop_clear", ch.Clear_bar, 0);
    tick();
    check("eq_stop_q", q, 8'h00);
    check("eq_idle_busy", Busy, 0);

    // Term_val < Load_val wraps through FF; RCO forced low
    Load_val = 8'hFE; Term_val = 8'h01; rco_kill = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tq("wr0", 8'hFE, 0);
    check("wr0_err", Err, 0);
    tq("wr1", 8'hFF, 0);
    check("wr1_err", Err, 0);
    tq("wr2", 8'h00, 0);
    check("wr2_err", Err, RCO_CHK);
    tq("wr3", 8'h01, 0);
    tq("wr4", 8'hFE, 1);
    check("wr4_err", Err, RCO_CHK);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    rco_kill = 1'b0;
    check("wr_stop_err", Err, 0);
    tick();

    // Asynchronous reset mid-run
    Load_val = 8'h05; Term_val = 8'h08;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tq("ar0", 8'h05, 0);
    #2 Reset_bar = 1'b0;
    #1;
    check("ar_clear", ch.Clear_bar, 0);
    check("ar_busy", Busy, 0);
    check("ar_ent", ch.ENT, 0);
    @(negedge Clk);
    Reset_bar = 1'b1;
    tick();
    check("ar_q", q, 8'h00);
    check("ar_clear_rel", ch.Clear_bar, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
